// File: rtl/sign_extender_pkg.sv
// sign_extender_pkg: shared constants and types for the RV32I immediate generator.
//
// Contents:
//   OP_*        7-bit major opcodes whose immediates the generator knows how to build.
//   imm_fmt_e   immediate-format code reported alongside the immediate.
//   is_known_op helper: true when an opcode is one of the nine decoded opcodes.
//
// The optional unknown-opcode flag is enabled with SIGN_EXTENDER_ILLEGAL_FLAG_EN
// (see sign_extender.sv and sign_extender_dec.sv).

package sign_extender_pkg;

  // Major opcodes (instruction bits [6:0]).
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Immediate format. FMT_NONE is also the reset and unknown-opcode value.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_J    = 3'd4,
    FMT_U    = 3'd5
  } imm_fmt_e;

  // True for the nine opcodes the decoder recognises. An X/Z opcode matches
  // none of the case items and therefore reports unknown.
  function automatic logic is_known_op(input logic [6:0] op);
    logic known;
    known = 1'b0;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_S, OP_B,
      OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: known = 1'b1;
      default:                           known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/sign_extender_dec.sv
// sign_extender_dec: purely combinational RV32I immediate decode.
//
// Builds the format-specific immediate from the instruction word, sign-extends
// it to 32 bits using inst_i[31], and selects it by the externally supplied
// opcode (the opcode field inside inst_i is deliberately ignored).
//
// Ports:
//   opcode_i   [6:0]  opcode from the control path
//   inst_i     [31:0] raw instruction word
//   imm_o      [31:0] sign-extended immediate (0 for R-type / unknown opcodes)
//   fmt_o      [2:0]  immediate format (imm_fmt_e)
//   illegal_o         high for any opcode outside the nine decoded ones;
//                     only present with SIGN_EXTENDER_ILLEGAL_FLAG_EN

module sign_extender_dec
  import sign_extender_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [31:0] inst_i,
  output logic [31:0] imm_o,
  output imm_fmt_e    fmt_o
`ifdef SIGN_EXTENDER_ILLEGAL_FLAG_EN
  ,
  output logic        illegal_o
`endif
);

  logic        sign;
  logic [31:0] imm_i_type;
  logic [31:0] imm_s_type;
  logic [31:0] imm_b_type;
  logic [31:0] imm_j_type;
  logic [31:0] imm_u_type;
  logic        op_unknown;

  assign sign = inst_i[31];

  // Candidate immediates for every format, built in parallel; the opcode only
  // steers the final mux so the decode is a single level of selection.
  assign imm_i_type = {{20{sign}}, inst_i[31:20]};
  assign imm_s_type = {{20{sign}}, inst_i[31:25], inst_i[11:7]};
  // B and J immediates are halfword offsets: bit 0 is hard-wired to zero.
  assign imm_b_type = {{19{sign}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j_type = {{11{sign}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_u_type = {inst_i[31:12], 12'b0};

  // Plain case with a default: an X or unrecognised opcode matches no item and
  // falls through to zero / FMT_NONE, keeping X out of the output register.
  always_comb begin
    imm_o = 32'b0;
    fmt_o = FMT_NONE;
    case (opcode_i)
      OP_R: begin
        imm_o = 32'b0;
        fmt_o = FMT_NONE;
      end
      OP_I, OP_LOAD, OP_JALR: begin
        imm_o = imm_i_type;
        fmt_o = FMT_I;
      end
      OP_S: begin
        imm_o = imm_s_type;
        fmt_o = FMT_S;
      end
      OP_B: begin
        imm_o = imm_b_type;
        fmt_o = FMT_B;
      end
      OP_JAL: begin
        imm_o = imm_j_type;
        fmt_o = FMT_J;
      end
      OP_LUI, OP_AUIPC: begin
        imm_o = imm_u_type;
        fmt_o = FMT_U;
      end
      default: begin
        imm_o = 32'b0;
        fmt_o = FMT_NONE;
      end
    endcase
  end

  assign op_unknown = ~is_known_op(opcode_i);

`ifdef SIGN_EXTENDER_ILLEGAL_FLAG_EN
  assign illegal_o = op_unknown;
`else
  logic unused_op_unknown;
  assign unused_op_unknown = op_unknown;
`endif

  // The opcode field of the word is never used; the control path owns opcode.
  logic unused_inst_opcode;
  assign unused_inst_opcode = ^inst_i[6:0];

endmodule

// File: rtl/sign_extender.sv
// sign_extender: registered RV32I immediate generator for the decode stage.
//
// Decodes the immediate for the given opcode, sign-extends it to 32 bits and
// registers it (one-cycle latency) so it lines up with the decode/execute
// pipeline register. The register loads every cycle; there is no stall.
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst        synchronous active-high reset (priority over new inputs)
//   opcode     [6:0]  opcode from the control path
//   instIn     [31:0] raw instruction word
//   immOut     [31:0] registered sign-extended immediate (reset 0)
//   immFmt     [2:0]  registered immediate format, imm_fmt_e (reset FMT_NONE)
//   illegalOp         registered unknown-opcode flag (reset 0); only present
//                     when SIGN_EXTENDER_ILLEGAL_FLAG_EN is defined

module sign_extender
  import sign_extender_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [31:0] instIn,
  output logic [31:0] immOut,
  output imm_fmt_e    immFmt
`ifdef SIGN_EXTENDER_ILLEGAL_FLAG_EN
  ,
  output logic        illegalOp
`endif
);

  logic [31:0] imm_d, imm_q;
  imm_fmt_e    fmt_d, fmt_q;

`ifdef SIGN_EXTENDER_ILLEGAL_FLAG_EN
  logic        illegal_d, illegal_q;
`endif

  sign_extender_dec u_dec (
    .opcode_i  (opcode),
    .inst_i    (instIn),
    .imm_o     (imm_d),
    .fmt_o     (fmt_d)
`ifdef SIGN_EXTENDER_ILLEGAL_FLAG_EN
    ,
    .illegal_o (illegal_d)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      imm_q <= 32'b0;
      fmt_q <= FMT_NONE;
    end else begin
      imm_q <= imm_d;
      fmt_q <= fmt_d;
    end
  end

`ifdef SIGN_EXTENDER_ILLEGAL_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegalOp = illegal_q;
`endif

  assign immOut = imm_q;
  assign immFmt = fmt_q;

endmodule

// File: tb/tb_sign_extender.sv
// tb_sign_extender: self-checking bench for sign_extender.
// Directed vectors, reset behaviour and randomised opcode/instruction pairs are
// compared against an arithmetic reference model of the RV32I immediate rules.

module tb_sign_extender;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [31:0] instIn;
  logic [31:0] immOut;
  logic [2:0]  immFmt;
`ifdef SIGN_EXTENDER_ILLEGAL_FLAG_EN
  logic        illegalOp;
`endif

  int unsigned n_checks;
  int unsigned n_pass;

  // Expected values of the currently registered outputs.
  logic [31:0] exp_imm;
  logic [2:0]  exp_fmt;
  logic        exp_ill;

  sign_extender dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .instIn    (instIn),
    .immOut    (immOut),
    .immFmt    (immFmt)
`ifdef SIGN_EXTENDER_ILLEGAL_FLAG_EN
    ,
    .illegalOp (illegalOp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: immediate value computed numerically from its field weights.
  function automatic void ref_model(input logic [6:0] op, input logic [31:0] in,
                                    output logic [31:0] imm, output logic [2:0] fmt,
                                    output logic ill);
    longint v;
    v   = 0;
    fmt = 3'd0;
    ill = 1'b0;
    case (op)
      7'b0110011: begin v = 0; fmt = 3'd0; end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        v = longint'(in[31:20]);
        if (v >= 2048) v = v - 4096;
        fmt = 3'd1;
      end
      7'b0100011: begin
        v = longint'(in[31:25]) * 32 + longint'(in[11:7]);
        if (v >= 2048) v = v - 4096;
        fmt = 3'd2;
      end
      7'b1100011: begin
        v = longint'(in[31]) * 4096 + longint'(in[7]) * 2048 +
            longint'(in[30:25]) * 32 + longint'(in[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
        fmt = 3'd3;
      end
      7'b1101111: begin
        v = longint'(in[31]) * 1048576 + longint'(in[19:12]) * 4096 +
            longint'(in[20]) * 2048 + longint'(in[30:21]) * 2;
        if (v >= 1048576) v = v - 2097152;
        fmt = 3'd4;
      end
      7'b0110111, 7'b0010111: begin
        v = longint'(in) - (longint'(in) % 4096);
        fmt = 3'd5;
      end
      default: begin v = 0; fmt = 3'd0; ill = 1'b1; end
    endcase
    imm = v[31:0];
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, ".imm"}, immOut, exp_imm);
    check_val({tag, ".fmt"}, {29'b0, immFmt}, {29'b0, exp_fmt});
`ifdef SIGN_EXTENDER_ILLEGAL_FLAG_EN
    check_val({tag, ".ill"}, {31'b0, illegalOp}, {31'b0, exp_ill});
`endif
  endtask

  // Apply one input pair (called just after a rising edge), confirm the outputs
  // still hold the previous result, then check the new result after the edge.
  task automatic step(input string tag, input logic [6:0] op, input logic [31:0] in,
                      input logic hold_chk);
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    opcode = op;
    instIn = in;
    #1;
    if (hold_chk) check_outputs({tag, ".hold"});
    ref_model(op, in, imm, fmt, ill);
    @(posedge clk);
    #1;
    exp_imm = imm;
    exp_fmt = fmt;
    exp_ill = ill;
    check_outputs(tag);
  endtask

  task automatic reset_cycle(input string tag);
    rst    = 1'b1;
    opcode = 7'($urandom);
    instIn = $urandom;
    @(posedge clk);
    #1;
    exp_imm = 32'b0;
    exp_fmt = 3'd0;
    exp_ill = 1'b0;
    check_outputs(tag);
    rst = 1'b0;
  endtask

  logic [6:0] legal_ops [9];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    opcode   = 7'b0;
    instIn   = 32'b0;
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111};

    @(posedge clk);
    #1;
    // Two reset cycles with arbitrary inputs.
    reset_cycle("rst0");
    rst = 1'b1;
    reset_cycle("rst1");

    // Directed vectors; each also checks the old value holds until the edge.
    step("i_neg1",  7'b0010011, 32'hfffb8b93, 1'b1);
    step("jalr",    7'b1100111, 32'h372080e7, 1'b1);
    step("load0",   7'b0000011, 32'h0002a303, 1'b1);
    step("s_type",  7'b0100011, 32'h0082a223, 1'b1);
    step("r_type",  7'b0110011, 32'h01190933, 1'b1);
    step("b_type",  7'b1100011, 32'h014c6463, 1'b1);
    step("jal0",    7'b1101111, 32'h0000006f, 1'b1);
    step("jal_neg", 7'b1101111, 32'h8000006f, 1'b1);
    step("lui",     7'b0110111, 32'h34487237, 1'b1);
    step("auipc",   7'b0010111, 32'h10000917, 1'b1);
    step("illegal", 7'b1111111, 32'hffffffff, 1'b1);
    step("b_neg",   7'b1100011, 32'hffffffff, 1'b1);
    step("j_all1",  7'b1101111, 32'hffffffff, 1'b1);
    step("s_neg",   7'b0100011, 32'h80000000, 1'b1);

    // Randomised stream with a mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      logic [6:0] op;
      if (i == 150) begin
        opcode = legal_ops[1];
        instIn = $urandom;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        exp_imm = 32'b0;
        exp_fmt = 3'd0;
        exp_ill = 1'b0;
        check_outputs("midrst");
        rst = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) op = 7'($urandom);
      else                           op = legal_ops[$urandom_range(0, 8)];
      step("rand", op, $urandom, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sign_extender.md
# sign_extender

RV32I immediate generator for the decode stage. It takes the 7-bit opcode and the full 32-bit instruction word, builds the format-specific immediate, and sign-extends it to 32 bits. The result is registered, so it lines up with the decode/execute pipeline register. The result feeds the ALU B-operand mux, the branch/jump target adder, and the LUI/AUIPC path.

## Interface
Parameters: none; widths are fixed by RV32I.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  instruction opcode, driven separately by the control path; never re-derived from `instIn[6:0]`.
- `instIn`  in  32  raw instruction word.
- `immOut`  out  32  registered, sign-extended immediate.
- `immFmt`  out  3  registered immediate-format code (`imm_fmt_e`).
- `illegalOp`  out  1  registered unknown-opcode flag; only present with `SIGN_EXTENDER_ILLEGAL_FLAG_EN`.

## Operation
Decode by `opcode`; imm bits are taken from `instIn`:
- 0110011 (R): imm = 0, fmt = FMT_NONE.
- 0010011 (I-ALU), 0000011 (load), 1100111 (JALR): sext([31:20]), fmt = FMT_I.
- 0100011 (S): sext({[31:25],[11:7]}), fmt = FMT_S.
- 1100011 (B): sext({[31],[7],[30:25],[11:8],1'b0}), fmt = FMT_B.
- 1101111 (JAL): sext({[31],[19:12],[20],[30:21],1'b0}), fmt = FMT_J.
- 0110111 (LUI), 0010111 (AUIPC): {[31:12],12'b0}, fmt = FMT_U.
- Any other opcode: imm = 0, fmt = FMT_NONE.

Rules:
- Sign bit is always `instIn[31]`.
- B and J immediates always have bit 0 = 0.
- No X-propagation beyond the register: an X or unknown opcode selects the default branch.

## Timing
- One-cycle latency: inputs sampled at rising edge N appear on the outputs after edge N.
- Reset values: `immOut` = 0x00000000, `immFmt` = FMT_NONE, `illegalOp` = 0.
- Reset has priority over new inputs at the same edge.
- Reset asserted mid-stream clears the outputs at the next edge. The first valid result appears one edge after `rst` deasserts.
- No handshake and no stall input: the register loads every cycle.
- The combinational decode must settle within one cycle, with no internal state beyond the output register.

## Configuration
Macro: `SIGN_EXTENDER_ILLEGAL_FLAG_EN`.
- Defined: the `illegalOp` port exists. It is registered high one cycle after any opcode outside the nine listed, and cleared by reset.
- Undefined: the port and its flop are absent. Decode behaviour is otherwise identical.

## Structure
- Package `sign_extender_pkg` holds:
  - localparams `OP_R`, `OP_I`, `OP_LOAD`, `OP_S`, `OP_B`, `OP_JALR`, `OP_JAL`, `OP_LUI`, `OP_AUIPC` (7-bit);
  - enum `imm_fmt_e` {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U}.
- One combinational sub-module, `sign_extender_dec` (opcode, instIn -> imm, fmt, illegal). The top level adds only the reset-able output register.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with arbitrary inputs -> `immOut`=0, `immFmt`=FMT_NONE, `illegalOp`=0.
- I-type: opcode 0010011, inst 0xfffb8b93 -> 0xFFFFFFFF, FMT_I. JALR: opcode 1100111, inst 0x372080e7 -> 0x00000372. Load: opcode 0000011, inst 0x0002a303 -> 0.
- S-type: opcode 0100011, inst 0x0082a223 -> 0x00000004, FMT_S. R-type: opcode 0110011, inst 0x01190933 -> 0, FMT_NONE.
- B-type: opcode 1100011, inst 0x014c6463 -> 0x00000008. JAL: opcode 1101111, inst 0x0000006f -> 0; inst 0x8000006f -> 0xFFF00000.
- U-type: LUI opcode 0110111, inst 0x34487237 -> 0x34487000. AUIPC opcode 0010111, inst 0x10000917 -> 0x10000000. Each result appears exactly one edge after its inputs.
- Illegal/mid-reset: opcode 1111111 -> `immOut`=0 and `illegalOp`=1 (macro defined). Assert `rst` during a stream of valid opcodes -> outputs zero at the next edge.
